// File: rtl/updown_counter_nbit.sv
// updown_counter_nbit: loadable up/down counter with a programmable terminal
// count (MAX), a registered wrap pulse (c) and a combinational terminal-count
// flag (tc). The +1/-1 paths are explicit ripple half-adder / half-subtractor
// chains rather than behavioural arithmetic.
//
// Optional feature: define UPDOWN_COUNTER_SAT_EN to let the sat input select
// saturate (sat=1) or wrap (sat=0) at the boundaries. Without the macro the
// counter always wraps and sat is ignored.
module updown_counter_nbit #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 2**WIDTH-1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             sat,
    output logic [WIDTH-1:0] q,
    output logic             c,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_Q = MAX[WIDTH-1:0];

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             c_reg;
    logic             c_next;

    logic [WIDTH-1:0] inc_sum;
    logic [WIDTH-1:0] inc_carry;
    logic [WIDTH-1:0] dec_diff;
    logic [WIDTH-1:0] dec_borrow;

    logic             at_max;
    logic             at_zero;
    logic             sat_mode;
    logic [WIDTH-1:0] load_val;

    // Ripple chains: the carry (borrow) into bit 0 is a constant 1, so each
    // stage is a half adder (half subtractor). The carry out of the top stage
    // is never needed, so the chain stops at WIDTH-1.
    assign inc_carry[0]  = 1'b1;
    assign dec_borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ripple
            assign inc_sum[gi]  = q_reg[gi] ^ inc_carry[gi];
            assign dec_diff[gi] = q_reg[gi] ^ dec_borrow[gi];
            if (gi < WIDTH-1) begin : g_chain
                assign inc_carry[gi+1]  = q_reg[gi] & inc_carry[gi];
                assign dec_borrow[gi+1] = ~q_reg[gi] & dec_borrow[gi];
            end
        end
    endgenerate

    assign at_max  = (q_reg == MAX_Q);
    assign at_zero = (q_reg == '0);

    // Loads above the terminal count are clamped so q can never exceed MAX.
    assign load_val = (d > MAX_Q) ? MAX_Q : d;

`ifdef UPDOWN_COUNTER_SAT_EN
    assign sat_mode = sat;
`else
    // Wrap-only build: sat is deliberately left unconnected to any logic.
    logic sat_unused;
    assign sat_unused = sat;
    assign sat_mode   = 1'b0;
`endif

    // Next-state selection: ld beats en; with neither, hold and clear c.
    always_comb begin
        q_next = q_reg;
        c_next = 1'b0;
        if (ld) begin
            q_next = load_val;
        end else if (en) begin
            if (up) begin
                if (!at_max) begin
                    q_next = inc_sum;
                end else if (!sat_mode) begin
                    q_next = '0;
                    c_next = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    q_next = dec_diff;
                end else if (!sat_mode) begin
                    q_next = MAX_Q;
                    c_next = 1'b1;
                end
            end
        end
    end

    // State register with synchronous reset overriding load and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
            c_reg <= 1'b0;
        end else begin
            q_reg <= q_next;
            c_reg <= c_next;
        end
    end

    assign q  = q_reg;
    assign c  = c_reg;
    assign tc = up ? at_max : at_zero;

endmodule

// File: tb/tb_updown_counter_nbit.sv
// Directed and randomised checks for updown_counter_nbit using three
// instances: 4-bit full range, 4-bit with MAX=9, and 8-bit full range.
// Sat-mode expectations follow UPDOWN_COUNTER_SAT_EN when it is defined.
module tb_updown_counter_nbit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Instance A: WIDTH=4, MAX=15
    logic       a_rst, a_en, a_up, a_ld, a_sat;
    logic [3:0] a_d, a_q;
    logic       a_c, a_tc;
    // Instance B: WIDTH=4, MAX=9
    logic       b_rst, b_en, b_up, b_ld, b_sat;
    logic [3:0] b_d, b_q;
    logic       b_c, b_tc;
    // Instance R: WIDTH=8, MAX=255 (random vs model)
    logic       r_rst, r_en, r_up, r_ld, r_sat;
    logic [7:0] r_d, r_q;
    logic       r_c, r_tc;

    updown_counter_nbit #(.WIDTH(4), .MAX(15)) dut_a (
        .clk(clk), .rst(a_rst), .en(a_en), .up(a_up), .ld(a_ld), .d(a_d),
        .sat(a_sat), .q(a_q), .c(a_c), .tc(a_tc)
    );

    updown_counter_nbit #(.WIDTH(4), .MAX(9)) dut_b (
        .clk(clk), .rst(b_rst), .en(b_en), .up(b_up), .ld(b_ld), .d(b_d),
        .sat(b_sat), .q(b_q), .c(b_c), .tc(b_tc)
    );

    updown_counter_nbit #(.WIDTH(8), .MAX(255)) dut_r (
        .clk(clk), .rst(r_rst), .en(r_en), .up(r_up), .ld(r_ld), .d(r_d),
        .sat(r_sat), .q(r_q), .c(r_c), .tc(r_tc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic sat_on;
    logic [7:0] m_q;
    logic       m_c;

    initial begin
`ifdef UPDOWN_COUNTER_SAT_EN
        sat_on = 1'b1;
`else
        sat_on = 1'b0;
`endif
        {a_rst, a_en, a_up, a_ld, a_sat, a_d} = {5'b10000, 4'd0};
        {b_rst, b_en, b_up, b_ld, b_sat, b_d} = {5'b10000, 4'd0};
        {r_rst, r_en, r_up, r_ld, r_sat, r_d} = {5'b10000, 8'd0};
        a_up = 1'b1;
        tick();

        // Reset state
        check("a_rst_q", 32'(a_q), 0);
        check("a_rst_c", 32'(a_c), 0);
        check("a_rst_tc_up", 32'(a_tc), 0);
        a_up = 1'b0;
        #1;
        check("a_rst_tc_down", 32'(a_tc), 1);

        // Full up count 0..15 then wrap to 0 with a one-cycle carry
        a_rst = 1'b0; a_en = 1'b1; a_up = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("a_up_q[%0d]", i), 32'(a_q), 32'(i % 16));
            check($sformatf("a_up_c[%0d]", i), 32'(a_c), (i == 16) ? 1 : 0);
            check($sformatf("a_up_tc[%0d]", i), 32'(a_tc), (i == 15) ? 1 : 0);
        end
        tick();
        check("a_after_wrap_q", 32'(a_q), 1);
        check("a_after_wrap_c", 32'(a_c), 0);

        // Down count from reset: borrow into 15 on the first edge
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0; a_up = 1'b0;
        tick();
        check("a_dn_q0", 32'(a_q), 15);
        check("a_dn_c0", 32'(a_c), 1);
        tick();
        check("a_dn_q1", 32'(a_q), 14);
        check("a_dn_c1", 32'(a_c), 0);
        tick();
        check("a_dn_q2", 32'(a_q), 13);

        // Hold with en=0
        a_en = 1'b0;
        tick();
        check("a_hold_q", 32'(a_q), 13);
        check("a_hold_c", 32'(a_c), 0);

        // rst beats ld, then ld beats en
        a_ld = 1'b1; a_d = 4'd7;
        tick();
        check("a_ld7_q", 32'(a_q), 7);
        a_en = 1'b1; a_up = 1'b1; a_d = 4'd3; a_rst = 1'b1;
        tick();
        check("a_rst_over_ld_q", 32'(a_q), 0);
        a_rst = 1'b0;
        tick();
        check("a_ld_over_en_q", 32'(a_q), 3);
        check("a_ld_over_en_c", 32'(a_c), 0);
        a_ld = 1'b0;
        tick();
        check("a_resume_q", 32'(a_q), 4);

        // Boundary behaviour with sat=1 (saturate only when the feature is built)
        a_sat = 1'b1; a_ld = 1'b1; a_d = 4'd15;
        tick();
        check("a_sat_ld_q", 32'(a_q), 15);
        a_ld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (sat_on) begin
                check($sformatf("a_sat_up_q[%0d]", i), 32'(a_q), 15);
                check($sformatf("a_sat_up_c[%0d]", i), 32'(a_c), 0);
                check($sformatf("a_sat_up_tc[%0d]", i), 32'(a_tc), 1);
            end else begin
                check($sformatf("a_wrapsat_up_q[%0d]", i), 32'(a_q), 32'(i));
                check($sformatf("a_wrapsat_up_c[%0d]", i), 32'(a_c), (i == 0) ? 1 : 0);
            end
        end
        a_ld = 1'b1; a_d = 4'd0; a_up = 1'b0;
        tick();
        a_ld = 1'b0;
        tick();
        check("a_sat_dn_q", 32'(a_q), sat_on ? 0 : 15);
        check("a_sat_dn_c", 32'(a_c), sat_on ? 0 : 1);
        a_sat = 1'b0;

        // Instance B: MAX=9, load clamp and wraps at the terminal count
        b_rst = 1'b0; b_ld = 1'b1; b_d = 4'd12; b_up = 1'b1;
        tick();
        check("b_clamp_q", 32'(b_q), 9);
        check("b_clamp_tc", 32'(b_tc), 1);
        b_ld = 1'b0; b_en = 1'b1;
        tick();
        check("b_wrap_q", 32'(b_q), 0);
        check("b_wrap_c", 32'(b_c), 1);
        check("b_wrap_tc", 32'(b_tc), 0);
        b_up = 1'b0;
        #1;
        check("b_tc_zero_down", 32'(b_tc), 1);
        tick();
        check("b_borrow_q", 32'(b_q), 9);
        check("b_borrow_c", 32'(b_c), 1);
        tick();
        check("b_dn_q", 32'(b_q), 8);
        b_ld = 1'b1; b_d = 4'd9; b_en = 1'b0;
        tick();
        check("b_ld_eq_max_q", 32'(b_q), 9);
        b_d = 4'd10;
        tick();
        check("b_ld_10_q", 32'(b_q), 9);

        // Instance R: random traffic against a behavioural reference model
        r_rst = 1'b1;
        tick();
        m_q = 8'd0; m_c = 1'b0;
        r_rst = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            r_ld  = ($urandom_range(0, 7) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_up  = $urandom_range(0, 1) != 0;
            r_sat = $urandom_range(0, 1) != 0;
            r_d   = 8'($urandom_range(0, 255));
            #1;
            check($sformatf("r_tc[%0d]", i), 32'(r_tc),
                  (r_up ? (m_q == 8'd255) : (m_q == 8'd0)) ? 1 : 0);
            // Reference update for the coming edge
            m_c = 1'b0;
            if (r_rst) begin
                m_q = 8'd0;
            end else if (r_ld) begin
                m_q = r_d;
            end else if (r_en) begin
                if (r_up) begin
                    if (m_q != 8'd255) m_q = m_q + 8'd1;
                    else if (!(sat_on && r_sat)) begin m_q = 8'd0; m_c = 1'b1; end
                end else begin
                    if (m_q != 8'd0) m_q = m_q - 8'd1;
                    else if (!(sat_on && r_sat)) begin m_q = 8'd255; m_c = 1'b1; end
                end
            end
            tick();
            check($sformatf("r_q[%0d]", i), 32'(r_q), 32'(m_q));
            check($sformatf("r_c[%0d]", i), 32'(r_c), 32'(m_c));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
